// File: rtl/transmissor_quadrante_serial_pkg.sv
// Shared constants, FSM state encoding and helpers for the quadrant serial transmitter.
// The 3x3 quadrant is scanned row-major; line/column indices live in 0..2.
package transmissor_quadrante_serial_pkg;

  localparam logic [7:0] HEADER_DEFAULT       = 8'hA5;
  localparam int         CLKS_PER_BIT_DEFAULT = 434;
  localparam int         PACKET_BYTES         = 20;
  localparam int         S_DATA               = 16;
  localparam logic [1:0] LAST_IDX             = 2'd2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HEADER,
    ST_ADDR,
    ST_WAIT,
    ST_SEND_MSB,
    ST_SEND_LSB,
    ST_CHECKSUM,
    ST_DONE
  } state_t;

  // Mod-3 increment for the line/column counters.
  function automatic logic [1:0] wrap_inc(input logic [1:0] v);
    return (v == LAST_IDX) ? 2'd0 : v + 2'd1;
  endfunction

endpackage

// File: rtl/transmissor_quadrante_serial_if.sv
// Handshake, RAM read port and serial line of the quadrant transmitter.
// The transmitter itself uses the slave modport; its controller/RAM side uses master.
interface transmissor_quadrante_serial_if;
  import transmissor_quadrante_serial_pkg::*;

  logic              iniciar;
  logic [1:0]        mem_addr_line;
  logic [1:0]        mem_addr_column;
  logic [S_DATA-1:0] mem_q;
  logic              saida_serial;
  logic              ocupado;
  logic              pronto;

  modport slave (
    input  iniciar, mem_q,
    output mem_addr_line, mem_addr_column, saida_serial, ocupado, pronto
  );

  modport master (
    output iniciar, mem_q,
    input  mem_addr_line, mem_addr_column, saida_serial, ocupado, pronto
  );

endinterface

// File: rtl/transmissor_quadrante_serial_tx_serial_8N1.sv
// 8N1 UART transmitter: start bit begins the clock after tx_partida, LSB first, idle high.
// tx_livre is forced low in the launch cycle so a caller never sees a stale "free".
module transmissor_quadrante_serial_tx_serial_8N1
  import transmissor_quadrante_serial_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       tx_partida,
  input  logic [7:0] tx_dado,
  output logic       saida_serial,
  output logic       tx_livre
);

  localparam int            CW      = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] BAUD_TC = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] baud_cnt_q;
  logic [3:0]    bits_left_q;
  logic [9:0]    shift_q;
  logic          busy_q;

  // Shifting in ones leaves the register all-ones after the stop bit, so the line idles high.
  always_ff @(posedge clock) begin
    if (reset) begin
      shift_q     <= '1;
      busy_q      <= 1'b0;
      baud_cnt_q  <= '0;
      bits_left_q <= '0;
    end else if (!busy_q) begin
      if (tx_partida) begin
        shift_q     <= {1'b1, tx_dado, 1'b0};
        busy_q      <= 1'b1;
        baud_cnt_q  <= BAUD_TC;
        bits_left_q <= 4'd9;
      end
    end else if (baud_cnt_q != '0) begin
      baud_cnt_q <= baud_cnt_q - CW'(1);
    end else if (bits_left_q != 4'd0) begin
      shift_q     <= {1'b1, shift_q[9:1]};
      bits_left_q <= bits_left_q - 4'd1;
      baud_cnt_q  <= BAUD_TC;
    end else begin
      busy_q <= 1'b0;
    end
  end

  assign saida_serial = shift_q[0];
  assign tx_livre     = !busy_q && !tx_partida;

endmodule

// File: rtl/transmissor_quadrante_serial.sv
// Scans the 3x3 RGB565 quadrant RAM and sends header, 18 pixel bytes (MSB first) and an XOR checksum.
//   state        | meaning
//   ST_IDLE      | waiting for a rising edge on iniciar
//   ST_HEADER    | launch header, clear checksum and line/column counters
//   ST_ADDR      | address on the RAM port settles
//   ST_WAIT      | latch mem_q into the pixel register
//   ST_SEND_MSB  | wait for the UART, launch pixel[15:8]
//   ST_SEND_LSB  | wait for the UART, launch pixel[7:0], step to the next cell
//   ST_CHECKSUM  | wait for the UART, launch the checksum byte
//   ST_DONE      | wait for the checksum stop bit, pulse pronto
module transmissor_quadrante_serial
  import transmissor_quadrante_serial_pkg::*;
#(
  parameter int         CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT,
  parameter logic [7:0] HEADER       = HEADER_DEFAULT
) (
  input  logic clock,
  input  logic reset,
  transmissor_quadrante_serial_if.slave bus
);

  state_t            state_q;
  logic [1:0]        line_q;
  logic [1:0]        col_q;
  logic [S_DATA-1:0] pixel_q;
  logic [7:0]        checksum_q;
  logic [7:0]        tx_dado_q;
  logic              tx_partida_q;
  logic              ocupado_q;
  logic              pronto_q;
  logic              iniciar_q;
  logic              tx_livre;
  logic              tx_saida;

  transmissor_quadrante_serial_tx_serial_8N1 #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_tx_serial_8N1 (
    .clock        (clock),
    .reset        (reset),
    .tx_partida   (tx_partida_q),
    .tx_dado      (tx_dado_q),
    .saida_serial (tx_saida),
    .tx_livre     (tx_livre)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      line_q       <= 2'd0;
      col_q        <= 2'd0;
      pixel_q      <= '0;
      checksum_q   <= 8'h00;
      tx_dado_q    <= 8'h00;
      tx_partida_q <= 1'b0;
      ocupado_q    <= 1'b0;
      pronto_q     <= 1'b0;
      iniciar_q    <= 1'b0;
    end else begin
      tx_partida_q <= 1'b0;
      pronto_q     <= 1'b0;
      iniciar_q    <= bus.iniciar;
      case (state_q)
        // Edge-triggered start so a level held through the packet yields one packet only.
        ST_IDLE: begin
          if (bus.iniciar && !iniciar_q) begin
            ocupado_q <= 1'b1;
            state_q   <= ST_HEADER;
          end
        end
        ST_HEADER: begin
          tx_partida_q <= 1'b1;
          tx_dado_q    <= HEADER;
          checksum_q   <= 8'h00;
          line_q       <= 2'd0;
          col_q        <= 2'd0;
          state_q      <= ST_ADDR;
        end
        ST_ADDR: state_q <= ST_WAIT;
        ST_WAIT: begin
          pixel_q <= bus.mem_q;
          state_q <= ST_SEND_MSB;
        end
        ST_SEND_MSB: begin
          if (tx_livre) begin
            tx_partida_q <= 1'b1;
            tx_dado_q    <= pixel_q[S_DATA-1 -: 8];
            checksum_q   <= checksum_q ^ pixel_q[S_DATA-1 -: 8];
            state_q      <= ST_SEND_LSB;
          end
        end
        ST_SEND_LSB: begin
          if (tx_livre) begin
            tx_partida_q <= 1'b1;
            tx_dado_q    <= pixel_q[7:0];
            checksum_q   <= checksum_q ^ pixel_q[7:0];
            if (line_q == LAST_IDX && col_q == LAST_IDX) begin
              state_q <= ST_CHECKSUM;
            end else begin
              col_q <= wrap_inc(col_q);
              if (col_q == LAST_IDX) line_q <= wrap_inc(line_q);
              state_q <= ST_ADDR;
            end
          end
        end
        ST_CHECKSUM: begin
          if (tx_livre) begin
            tx_partida_q <= 1'b1;
            tx_dado_q    <= checksum_q;
            state_q      <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (tx_livre) begin
            pronto_q  <= 1'b1;
            ocupado_q <= 1'b0;
            state_q   <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign bus.mem_addr_line   = line_q;
  assign bus.mem_addr_column = col_q;
  assign bus.saida_serial    = tx_saida;
  assign bus.ocupado         = ocupado_q;
  assign bus.pronto          = pronto_q;

endmodule

// File: tb/tb_transmissor_quadrante_serial.sv
// Bench for the quadrant transmitter: synchronous RAM model with garbage on address change,
// a UART frame monitor, and a packet reference built from the RAM contents.
module tb_transmissor_quadrante_serial;
  import transmissor_quadrante_serial_pkg::*;

  localparam int CPB    = 4;
  localparam int BUDGET = 3000;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  transmissor_quadrante_serial_if bus();

  transmissor_quadrante_serial #(.CLKS_PER_BIT(CPB)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  logic [15:0] ram [3][3];
  logic [7:0]  exp_q[$];
  logic [7:0]  rx_q[$];
  int          gap_q[$];
  logic [3:0]  addr_chg_q[$];

  logic [3:0] last_addr = 4'h0;
  logic [3:0] mon_prev_addr = 4'h0;
  int   cyc = 0, frame_err = 0, addr_bad = 0, ocup_err = 0;
  int   pronto_rises = 0, pronto_hi = 0, pronto_cyc = 0, stop_last_cyc = 0;
  logic pronto_prev = 1'b0;
  bit   mon_active = 0, mon_bad = 0;
  int   mon_pos = 0, idle_run = 0;
  logic [9:0] mon_bits = '0;

  // RAM: data valid from the second cycle an address is held; random junk right after a change.
  always begin
    logic [3:0] cur;
    @(posedge clock);
    #1;
    cur = {bus.mem_addr_line, bus.mem_addr_column};
    if (cur != last_addr || cur[3:2] == 2'd3 || cur[1:0] == 2'd3) bus.mem_q = 16'($urandom);
    else bus.mem_q = ram[cur[3:2]][cur[1:0]];
    last_addr = cur;
  end

  // UART monitor: every bit must hold for exactly CPB samples.
  always begin
    logic ser;
    int   bitn;
    @(posedge clock);
    #1;
    cyc++;
    ser = bus.saida_serial;
    if (bus.mem_addr_line == 2'd3 || bus.mem_addr_column == 2'd3) addr_bad++;
    if ({bus.mem_addr_line, bus.mem_addr_column} != mon_prev_addr) begin
      mon_prev_addr = {bus.mem_addr_line, bus.mem_addr_column};
      addr_chg_q.push_back(mon_prev_addr);
    end
    if (bus.pronto === 1'b1) begin
      pronto_hi++;
      if (!pronto_prev) begin
        pronto_rises++;
        pronto_cyc = cyc;
      end
      if (bus.ocupado !== 1'b0) ocup_err++;
    end
    pronto_prev = bus.pronto;
    if (reset) begin
      mon_active = 0;
      idle_run   = 0;
    end else if (!mon_active) begin
      if (ser === 1'b0) begin
        mon_active  = 1;
        mon_bad     = 0;
        mon_pos     = 1;
        mon_bits[0] = 1'b0;
        gap_q.push_back(idle_run);
      end else begin
        idle_run++;
      end
    end else begin
      bitn = mon_pos / CPB;
      if (mon_pos % CPB == 0) mon_bits[bitn] = ser;
      else if (ser !== mon_bits[bitn]) mon_bad = 1;
      if (mon_pos == 10 * CPB - 1) begin
        mon_active = 0;
        idle_run   = 0;
        stop_last_cyc = cyc;
        rx_q.push_back(mon_bits[8:1]);
        if (mon_bad || mon_bits[0] !== 1'b0 || mon_bits[9] !== 1'b1) frame_err++;
      end else begin
        mon_pos++;
      end
    end
  end

  task automatic fill_ram(input int mode);
    for (int l = 0; l < 3; l++)
      for (int c = 0; c < 3; c++)
        case (mode)
          0:       ram[l][c] = 16'h1000 + 16'(3 * l + c);
          1:       ram[l][c] = 16'hFFFF;
          default: ram[l][c] = 16'($urandom);
        endcase
  endtask

  // Reference packet: header, each pixel MSB then LSB in row-major order, XOR of the 18 pixel bytes.
  task automatic build_expected();
    logic [7:0] cs, hi, lo;
    exp_q.delete();
    exp_q.push_back(8'hA5);
    cs = 8'h00;
    for (int l = 0; l < 3; l++)
      for (int c = 0; c < 3; c++) begin
        hi = 8'(ram[l][c] / 256);
        lo = 8'(ram[l][c] % 256);
        exp_q.push_back(hi);
        exp_q.push_back(lo);
        cs = cs ^ hi ^ lo;
      end
    exp_q.push_back(cs);
  endtask

  task automatic run_packet(input bit hold, output int lat, output bit tmo);
    int n;
    int p0;
    rx_q.delete();
    gap_q.delete();
    addr_chg_q.delete();
    p0 = pronto_rises;
    @(posedge clock);
    #2;
    bus.iniciar = 1'b1;
    lat = 0;
    while (bus.saida_serial === 1'b1 && lat < 20) begin
      @(posedge clock);
      #2;
      lat++;
      if (!hold) bus.iniciar = 1'b0;
    end
    if (!hold) bus.iniciar = 1'b0;
    n = 0;
    while (pronto_rises == p0 && n < BUDGET) begin
      @(posedge clock);
      #2;
      n++;
    end
    tmo = (n >= BUDGET);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge clock);
    #2;
    checks++;
    if (bus.saida_serial !== 1'b1) begin errors++; $display("FAIL reset_serial got %b want 1", bus.saida_serial); end
    checks++;
    if (bus.ocupado !== 1'b0) begin errors++; $display("FAIL reset_ocupado got %b want 0", bus.ocupado); end
    checks++;
    if (bus.pronto !== 1'b0) begin errors++; $display("FAIL reset_pronto got %b want 0", bus.pronto); end
    checks++;
    if ({bus.mem_addr_line, bus.mem_addr_column} !== 4'h0) begin
      errors++;
      $display("FAIL reset_addr got %0d,%0d want 0,0", bus.mem_addr_line, bus.mem_addr_column);
    end
    reset = 1'b0;
    repeat (3) @(posedge clock);
  endtask

  task automatic test_pattern(input int mode, input string name);
    int lat, p0, hi0, fe0, ab0, oe0, bad, maxgap, plat;
    bit tmo;
    logic [3:0] prev;
    logic [3:0] exp_addr[$];
    fill_ram(mode);
    build_expected();
    prev = {bus.mem_addr_line, bus.mem_addr_column};
    for (int l = 0; l < 3; l++)
      for (int c = 0; c < 3; c++)
        if ({2'(l), 2'(c)} != prev) begin
          prev = {2'(l), 2'(c)};
          exp_addr.push_back(prev);
        end
    p0 = pronto_rises; hi0 = pronto_hi; fe0 = frame_err; ab0 = addr_bad; oe0 = ocup_err;
    run_packet(1'b0, lat, tmo);
    plat = pronto_cyc - stop_last_cyc - 1;
    repeat (6) @(posedge clock);
    #2;
    checks++;
    if (tmo) begin errors++; $display("FAIL %s timeout waiting for pronto", name); end
    checks++;
    if (lat > 3) begin errors++; $display("FAIL %s start_latency got %0d want <=3", name, lat); end
    checks++;
    if (rx_q.size() != PACKET_BYTES) begin
      errors++;
      $display("FAIL %s byte_count got %0d want %0d", name, rx_q.size(), PACKET_BYTES);
    end else begin
      bad = 0;
      for (int i = 0; i < PACKET_BYTES; i++)
        if (rx_q[i] !== exp_q[i]) begin
          bad++;
          $display("FAIL %s byte%0d got %02h want %02h", name, i, rx_q[i], exp_q[i]);
        end
      if (bad != 0) errors++;
    end
    checks++;
    if (frame_err != fe0) begin errors++; $display("FAIL %s framing got %0d bad frames want 0", name, frame_err - fe0); end
    maxgap = 0;
    for (int i = 1; i < gap_q.size(); i++) if (gap_q[i] > maxgap) maxgap = gap_q[i];
    checks++;
    if (maxgap > 2) begin errors++; $display("FAIL %s byte_gap got %0d want <=2", name, maxgap); end
    checks++;
    if (pronto_rises - p0 != 1 || pronto_hi - hi0 != 1) begin
      errors++;
      $display("FAIL %s pronto pulses %0d cycles %0d want 1 1", name, pronto_rises - p0, pronto_hi - hi0);
    end
    checks++;
    if (plat < 0 || plat > 3) begin errors++; $display("FAIL %s pronto_latency got %0d want 0..3", name, plat); end
    checks++;
    if (bus.ocupado !== 1'b0 || ocup_err != oe0) begin
      errors++;
      $display("FAIL %s ocupado got %b (overlap %0d) want 0", name, bus.ocupado, ocup_err - oe0);
    end
    checks++;
    if (addr_chg_q != exp_addr || addr_bad != ab0) begin
      errors++;
      $display("FAIL %s addr_seq got %0d changes (%0d out of range) want %0d", name, addr_chg_q.size(),
               addr_bad - ab0, exp_addr.size());
    end
  endtask

  task automatic test_hold_iniciar();
    int lat, p0;
    bit tmo;
    fill_ram(2);
    build_expected();
    p0 = pronto_rises;
    run_packet(1'b1, lat, tmo);
    repeat (150) @(posedge clock);
    #2;
    checks++;
    if (tmo || pronto_rises - p0 != 1) begin
      errors++;
      $display("FAIL hold_iniciar packets got %0d (timeout %0d) want 1", pronto_rises - p0, tmo);
    end
    checks++;
    if (rx_q.size() != PACKET_BYTES || rx_q != exp_q) begin
      errors++;
      $display("FAIL hold_iniciar bytes got %0d want %0d matching", rx_q.size(), PACKET_BYTES);
    end
    checks++;
    if (bus.ocupado !== 1'b0 || bus.saida_serial !== 1'b1) begin
      errors++;
      $display("FAIL hold_iniciar idle ocupado %b serial %b want 0 1", bus.ocupado, bus.saida_serial);
    end
    bus.iniciar = 1'b0;
    repeat (3) @(posedge clock);
  endtask

  task automatic test_back_to_back();
    int lat;
    bit tmo1, tmo2;
    logic [7:0] first[$];
    fill_ram(2);
    build_expected();
    run_packet(1'b0, lat, tmo1);
    first = rx_q;
    run_packet(1'b0, lat, tmo2);
    repeat (4) @(posedge clock);
    checks++;
    if (tmo1 || tmo2 || first != exp_q || rx_q != exp_q) begin
      errors++;
      $display("FAIL back_to_back sizes got %0d,%0d timeouts %0d,%0d want %0d identical", first.size(),
               rx_q.size(), tmo1, tmo2, PACKET_BYTES);
    end
  endtask

  task automatic test_reset_mid();
    int n, p0, lat;
    bit tmo;
    fill_ram(0);
    build_expected();
    rx_q.delete();
    p0 = pronto_rises;
    @(posedge clock);
    #2;
    bus.iniciar = 1'b1;
    @(posedge clock);
    #2;
    bus.iniciar = 1'b0;
    n = 0;
    while (rx_q.size() < 6 && n < BUDGET) begin
      @(posedge clock);
      #2;
      n++;
    end
    checks++;
    if (n >= BUDGET) begin errors++; $display("FAIL reset_mid timeout reaching byte 7 got %0d bytes", rx_q.size()); end
    repeat (12) @(posedge clock);
    #2;
    checks++;
    if (bus.ocupado !== 1'b1) begin errors++; $display("FAIL reset_mid busy_before got %b want 1", bus.ocupado); end
    reset = 1'b1;
    @(posedge clock);
    #2;
    checks++;
    if (bus.saida_serial !== 1'b1 || bus.ocupado !== 1'b0 || bus.pronto !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid abort serial %b ocupado %b pronto %b want 1 0 0", bus.saida_serial, bus.ocupado,
               bus.pronto);
    end
    @(posedge clock);
    #2;
    reset = 1'b0;
    repeat (300) @(posedge clock);
    #2;
    checks++;
    if (pronto_rises != p0 || bus.saida_serial !== 1'b1) begin
      errors++;
      $display("FAIL reset_mid after_abort pronto %0d serial %b want 0 1", pronto_rises - p0, bus.saida_serial);
    end
    run_packet(1'b0, lat, tmo);
    repeat (4) @(posedge clock);
    checks++;
    if (tmo || rx_q != exp_q) begin
      errors++;
      $display("FAIL reset_mid restart bytes got %0d timeout %0d want %0d matching", rx_q.size(), tmo, PACKET_BYTES);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog simulation did not complete");
    $fatal(1);
  end

  initial begin
    bus.iniciar = 1'b0;
    bus.mem_q   = 16'h0000;
    fill_ram(0);
    test_reset();
    test_pattern(0, "incrementing");
    test_pattern(1, "all_ones");
    for (int k = 0; k < 3; k++) test_pattern(2, "random");
    test_hold_iniciar();
    test_back_to_back();
    test_reset_mid();
    test_pattern(2, "after_reset");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
